wr_back_buffer: RTL and testbench

WR_BACK_BUFFER -- requirements
Module: wr_back_buffer

---
 rtl/cache_pkg.sv | 19 +
 rtl/wr_back_cam.sv | 34 +++
 rtl/wr_back_buffer.sv | 164 ++++++++++++++++
 tb/tb_wr_back_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache geometry and the write-back buffer entry type.
package CachePkg;

    localparam int unsigned ADDR_BITS = 32;
    localparam int unsigned LINE_BITS = 32;
    localparam int unsigned OFFS_BITS = 6;

    typedef logic [ADDR_BITS-1:0] CacheAddr_t;

    // Keeps the line-address bits and clears the byte offset within the line.
    localparam CacheAddr_t LINE_MASK = {{(ADDR_BITS-OFFS_BITS){1'b1}}, {OFFS_BITS{1'b0}}};

    typedef struct packed {
        logic                 Valid;
        CacheAddr_t           Addr;
        logic [LINE_BITS-1:0] Data;
    } WbEntry_t;

endpackage

// File: rtl/wr_back_cam.sv
// Fully associative line-address match over the buffer, picking the youngest hit.
module wr_back_cam
    import CachePkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]                valid,
    input  logic [DEPTH-1:0][ADDR_BITS-1:0] addrs,
    input  logic [ADDR_BITS-1:0]            key,
    input  logic [$clog2(DEPTH)-1:0]        head,
    input  logic                            skip_head,
    output logic                            hit,
    output logic [$clog2(DEPTH)-1:0]        idx
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] p;

    // Walk from head towards tail so the last match found is the youngest.
    always_comb begin
        hit = 1'b0;
        idx = head;
        p   = head;
        for (int k = 0; k < DEPTH; k++) begin
            p = head + PTR_W'(k);
            if (valid[p] && (((key ^ addrs[p]) & LINE_MASK) == '0) && !(skip_head && k == 0)) begin
                hit = 1'b1;
                idx = p;
            end
        end
    end

endmodule

// File: rtl/wr_back_buffer.sv
// Write-back buffer between cache evictions and memory, with coalescing and fill lookup.
module wr_back_buffer
    import CachePkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [ADDR_BITS-1:0]     WbAddr,
    input  logic [LINE_BITS-1:0]     WbData,
    input  logic                     WbVal,
    output logic                     WbRdy,
    output logic [ADDR_BITS-1:0]     MemWrAddr,
    output logic [LINE_BITS-1:0]     MemWrData,
    output logic                     MemWrVal,
    input  logic                     MemWrRdy,
    input  logic [ADDR_BITS-1:0]     FillAddr,
    input  logic                     FillLookupEn,
    output logic                     FillHit,
    output logic [LINE_BITS-1:0]     FillData,
    input  logic                     FlushReq,
    output logic                     FlushDone,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty,
    output logic                     Full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    WbEntry_t               entries [DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;
    logic [0:0]             state;
    logic                   fill_hit;
    logic [LINE_BITS-1:0]   fill_data;
    logic                   flush_done;

    logic [DEPTH-1:0]                valid_vec;
    logic [DEPTH-1:0][ADDR_BITS-1:0] addr_vec;
    logic                            co_hit;
    logic [PTR_W-1:0]                co_idx;
    logic                            lk_hit;
    logic [PTR_W-1:0]                lk_idx;
    logic                            empty;
    logic                            full;
    logic                            push;
    logic                            pop;
    logic                            alloc;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries[i].Valid;
            addr_vec[i]  = entries[i].Addr;
        end
    end

    // Coalescing never targets the head, which memory may be consuming right now.
    wr_back_cam #(.DEPTH(DEPTH)) u_push_cam (
        .valid     (valid_vec),
        .addrs     (addr_vec),
        .key       (WbAddr),
        .head      (head),
        .skip_head (1'b1),
        .hit       (co_hit),
        .idx       (co_idx)
    );

    wr_back_cam #(.DEPTH(DEPTH)) u_fill_cam (
        .valid     (valid_vec),
        .addrs     (addr_vec),
        .key       (FillAddr),
        .head      (head),
        .skip_head (1'b0),
        .hit       (lk_hit),
        .idx       (lk_idx)
    );

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign WbRdy = !full && (state == ST_IDLE);
    assign push  = WbVal && WbRdy;
    assign pop   = !empty && MemWrRdy;
    assign alloc = push && !co_hit;

    assign MemWrVal  = !empty;
    assign MemWrAddr = entries[head].Addr;
    assign MemWrData = entries[head].Data;
    assign FillHit   = fill_hit;
    assign FillData  = fill_data;
    assign FlushDone = flush_done;
    assign Count     = count;
    assign Empty     = empty;
    assign Full      = full;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                entries[head].Valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (push && co_hit) begin
                entries[co_idx].Data <= WbData;
            end
            if (alloc) begin
                entries[tail] <= '{Valid: 1'b1, Addr: WbAddr & LINE_MASK, Data: WbData};
                tail          <= tail + 1'b1;
            end
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fill_hit  <= 1'b0;
            fill_data <= '0;
        end else if (FillLookupEn) begin
            fill_hit  <= lk_hit;
            fill_data <= lk_hit ? entries[lk_idx].Data : '0;
        end else begin
            fill_hit  <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= ST_IDLE;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (FlushReq) begin
                        // Nothing to drain: acknowledge straight away.
                        if (empty && !push) begin
                            flush_done <= 1'b1;
                        end else begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (empty) begin
                        state      <= ST_IDLE;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_back_buffer.sv
// Directed self-checking bench for wr_back_buffer (DEPTH=4, 64-byte lines).
module tb_wr_back_buffer;

    logic        Clk;
    logic        Rst;
    logic [31:0] WbAddr;
    logic [31:0] WbData;
    logic        WbVal;
    logic        WbRdy;
    logic [31:0] MemWrAddr;
    logic [31:0] MemWrData;
    logic        MemWrVal;
    logic        MemWrRdy;
    logic [31:0] FillAddr;
    logic        FillLookupEn;
    logic        FillHit;
    logic [31:0] FillData;
    logic        FlushReq;
    logic        FlushDone;
    logic [2:0]  Count;
    logic        Empty;
    logic        Full;

    int n_checks = 0;
    int n_fail   = 0;

    wr_back_buffer #(.DEPTH(4)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .WbAddr       (WbAddr),
        .WbData       (WbData),
        .WbVal        (WbVal),
        .WbRdy        (WbRdy),
        .MemWrAddr    (MemWrAddr),
        .MemWrData    (MemWrData),
        .MemWrVal     (MemWrVal),
        .MemWrRdy     (MemWrRdy),
        .FillAddr     (FillAddr),
        .FillLookupEn (FillLookupEn),
        .FillHit      (FillHit),
        .FillData     (FillData),
        .FlushReq     (FlushReq),
        .FlushDone    (FlushDone),
        .Count        (Count),
        .Empty        (Empty),
        .Full         (Full)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        WbAddr = a;
        WbData = d;
        WbVal  = 1'b1;
        tick();
        WbVal  = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_val"}, 64'(MemWrVal), 64'd1);
        check({tag, "_addr"}, 64'(MemWrAddr), 64'(a));
        check({tag, "_data"}, 64'(MemWrData), 64'(d));
        MemWrRdy = 1'b1;
        tick();
        MemWrRdy = 1'b0;
    endtask

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] seq_addr[4];
    bit          seen;

    initial begin
        Rst = 1'b0; WbAddr = '0; WbData = '0; WbVal = 1'b0; MemWrRdy = 1'b0;
        FillAddr = '0; FillLookupEn = 1'b0; FlushReq = 1'b0;
        seq_addr[0] = 32'h100; seq_addr[1] = 32'h140; seq_addr[2] = 32'h180; seq_addr[3] = 32'h1C0;
        #12;
        check("rst_empty", 64'(Empty), 64'd1);
        check("rst_full", 64'(Full), 64'd0);
        check("rst_memval", 64'(MemWrVal), 64'd0);
        check("rst_count", 64'(Count), 64'd0);
        tick();
        Rst = 1'b1;
        tick();
        check("rst_wbrdy", 64'(WbRdy), 64'd1);
        check("rst_fillhit", 64'(FillHit), 64'd0);
        check("rst_filldata", 64'(FillData), 64'd0);
        check("rst_flushdone", 64'(FlushDone), 64'd0);

        // Fill to full, then drain in order.
        for (int i = 0; i < 4; i++) push(seq_addr[i], 32'h11 * (i + 1));
        check("full_count", 64'(Count), 64'd4);
        check("full_full", 64'(Full), 64'd1);
        check("full_wbrdy", 64'(WbRdy), 64'd0);
        for (int i = 0; i < 4; i++) pop_expect("drain", seq_addr[i], 32'h11 * (i + 1));
        check("drain_empty", 64'(Empty), 64'd1);

        // Coalescing into a non-head entry; a head match allocates.
        push(32'h100, 32'hD1);
        push(32'h140, 32'hD2);
        push(32'h140, 32'hBEEF);
        check("coal_count", 64'(Count), 64'd2);
        push(32'h100, 32'hD3);
        check("head_alloc_count", 64'(Count), 64'd3);
        pop_expect("coal0", 32'h100, 32'hD1);
        pop_expect("coal1", 32'h140, 32'hBEEF);
        pop_expect("coal2", 32'h100, 32'hD3);

        // Fill lookup with offset ignored, miss, youngest-wins, and same-cycle pop.
        push(32'h200, 32'hAA);
        FillAddr = 32'h208; FillLookupEn = 1'b1;
        tick();
        FillLookupEn = 1'b0;
        check("lk_hit", 64'(FillHit), 64'd1);
        check("lk_data", 64'(FillData), 64'hAA);
        FillAddr = 32'h240; FillLookupEn = 1'b1;
        tick();
        FillLookupEn = 1'b0;
        check("lk_miss_hit", 64'(FillHit), 64'd0);
        check("lk_miss_data", 64'(FillData), 64'd0);
        push(32'h204, 32'hBB);
        check("lk_headmatch_count", 64'(Count), 64'd2);
        FillAddr = 32'h200; FillLookupEn = 1'b1;
        tick();
        FillLookupEn = 1'b0;
        check("lk_young_data", 64'(FillData), 64'hBB);
        tick();
        check("lk_idle_hit", 64'(FillHit), 64'd0);
        check("lk_hold_data", 64'(FillData), 64'hBB);
        pop_expect("lk_pop0", 32'h200, 32'hAA);
        check("lk_pop1_addr", 64'(MemWrAddr), 64'h200);
        MemWrRdy = 1'b1; FillLookupEn = 1'b1;
        tick();
        MemWrRdy = 1'b0; FillLookupEn = 1'b0;
        check("lk_popped_hit", 64'(FillHit), 64'd1);
        check("lk_popped_data", 64'(FillData), 64'hBB);
        check("lk_popped_empty", 64'(Empty), 64'd1);

        // Simultaneous push/pop across pointer wrap.
        q_addr.delete(); q_data.delete();
        push(32'h800, 32'h50); q_addr.push_back(32'h800); q_data.push_back(32'h50);
        push(32'h840, 32'h51); q_addr.push_back(32'h840); q_data.push_back(32'h51);
        for (int i = 0; i < 10; i++) begin
            check("wrap_head_addr", 64'(MemWrAddr), 64'(q_addr[0]));
            check("wrap_head_data", 64'(MemWrData), 64'(q_data[0]));
            WbAddr = 32'h1000 + 32'(i) * 32'h40; WbData = 32'h60 + 32'(i);
            WbVal = 1'b1; MemWrRdy = 1'b1;
            tick();
            void'(q_addr.pop_front()); void'(q_data.pop_front());
            q_addr.push_back(WbAddr); q_data.push_back(WbData);
            check("wrap_count", 64'(Count), 64'd2);
        end
        // Coalesced push with a pop shrinks the buffer.
        WbAddr = q_addr[1] | 32'h4; WbData = 32'hC0DE;
        tick();
        WbVal = 1'b0; MemWrRdy = 1'b0;
        check("coalpop_count", 64'(Count), 64'd1);
        pop_expect("coalpop", q_addr[1], 32'hC0DE);

        // Flush with a pending eviction held off.
        push(32'h300, 32'h1); push(32'h340, 32'h2); push(32'h380, 32'h3);
        FlushReq = 1'b1;
        tick();
        FlushReq = 1'b0;
        WbAddr = 32'h3C0; WbData = 32'h4; WbVal = 1'b1;
        check("flush_wbrdy", 64'(WbRdy), 64'd0);
        check("flush_count", 64'(Count), 64'd3);
        MemWrRdy = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (FlushDone) seen = 1'b1;
            else check("flush_block", 64'(WbRdy), 64'd0);
        end
        MemWrRdy = 1'b0;
        check("flush_done_seen", 64'(seen), 64'd1);
        check("flush_done_count", 64'(Count), 64'd0);
        check("flush_done_wbrdy", 64'(WbRdy), 64'd1);
        tick();
        WbVal = 1'b0;
        check("flush_pulse_end", 64'(FlushDone), 64'd0);
        check("flush_held_push", 64'(Count), 64'd1);
        pop_expect("flush_held", 32'h3C0, 32'h4);
        FlushReq = 1'b1;
        tick();
        FlushReq = 1'b0;
        check("flush_empty_done", 64'(FlushDone), 64'd1);
        tick();
        check("flush_empty_pulse", 64'(FlushDone), 64'd0);

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 4; i++) push(seq_addr[i], 32'h70 + 32'(i));
        MemWrRdy = 1'b1;
        tick();
        check("mid_count", 64'(Count), 64'd3);
        #1 Rst = 1'b0;
        #1;
        check("arst_memval", 64'(MemWrVal), 64'd0);
        check("arst_empty", 64'(Empty), 64'd1);
        check("arst_count", 64'(Count), 64'd0);
        MemWrRdy = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        check("arst_wbrdy", 64'(WbRdy), 64'd1);
        check("arst_still_empty", 64'(Empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
